// File: rtl/instr_encoder_if.sv
// Request/response bundle of the instruction encoder: symbolic request in,
// encoded word out, both with valid/ready flow control.
interface instr_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;

  // Handshake: a transfer happens on a rising clock edge where valid&ready are
  // both high; a producer holds valid and its payload stable until that edge.
  modport master (
    output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, out_ready,
    input  req_ready, out_valid, out_instr, out_last
  );

  modport slave (
    input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, out_ready,
    output req_ready, out_valid, out_instr, out_last
  );
endinterface

// File: rtl/instr_encoder.sv
// Assembles RV64I-subset instruction words from symbolic requests; the LI
// pseudo-op expands to LUI+ADDI when the value does not fit in 12 bits.
module instr_encoder #(
  parameter int SHAMT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  instr_encoder_if.slave  bus,
  output logic            err,
  output logic            busy,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LI2  = 2'd1
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_SLL  = 5'd2,
                         OP_SLT  = 5'd3,  OP_AND  = 5'd4,  OP_ADDI = 5'd5,
                         OP_SLTI = 5'd6,  OP_SLLI = 5'd7,  OP_SRLI = 5'd8,
                         OP_SRAI = 5'd9,  OP_LD   = 5'd10, OP_LW   = 5'd11,
                         OP_LH   = 5'd12, OP_LBU  = 5'd13, OP_SD   = 5'd14,
                         OP_SW   = 5'd15, OP_BEQ  = 5'd16, OP_BNE  = 5'd17,
                         OP_BLT  = 5'd18, OP_BGE  = 5'd19, OP_JAL  = 5'd20,
                         OP_JALR = 5'd21, OP_LUI  = 5'd22, OP_NOP  = 5'd23,
                         OP_BRK  = 5'd24, OP_LI   = 5'd25;

  localparam logic [6:0] OPC_R    = 7'b0110011, OPC_IMM  = 7'b0010011,
                         OPC_LOAD = 7'b0000011, OPC_ST   = 7'b0100011,
                         OPC_BR   = 7'b1100011, OPC_JAL  = 7'b1101111,
                         OPC_JALR = 7'b1100111, OPC_LUI  = 7'b0110111;

  // Single-word encoding; LI here is only its short ADDI rd,x0,imm form.
  function automatic logic [31:0] encode(input logic [4:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [31:0] imm);
    logic [5:0] sh;
    sh = 6'(imm[SHAMT_W-1:0]);
    encode = 32'h0;
    case (op)
      OP_ADD:  encode = {7'b0000000, rs2, rs1, 3'b000, rd, OPC_R};
      OP_SUB:  encode = {7'b0100000, rs2, rs1, 3'b000, rd, OPC_R};
      OP_SLL:  encode = {7'b0000000, rs2, rs1, 3'b001, rd, OPC_R};
      OP_SLT:  encode = {7'b0000000, rs2, rs1, 3'b010, rd, OPC_R};
      OP_AND:  encode = {7'b0000000, rs2, rs1, 3'b111, rd, OPC_R};
      OP_ADDI: encode = {imm[11:0], rs1, 3'b000, rd, OPC_IMM};
      OP_SLTI: encode = {imm[11:0], rs1, 3'b010, rd, OPC_IMM};
      OP_SLLI: encode = {6'b000000, sh, rs1, 3'b001, rd, OPC_IMM};
      OP_SRLI: encode = {6'b000000, sh, rs1, 3'b101, rd, OPC_IMM};
      OP_SRAI: encode = {6'b010000, sh, rs1, 3'b101, rd, OPC_IMM};
      OP_LD:   encode = {imm[11:0], rs1, 3'b011, rd, OPC_LOAD};
      OP_LW:   encode = {imm[11:0], rs1, 3'b010, rd, OPC_LOAD};
      OP_LH:   encode = {imm[11:0], rs1, 3'b001, rd, OPC_LOAD};
      OP_LBU:  encode = {imm[11:0], rs1, 3'b100, rd, OPC_LOAD};
      OP_SD:   encode = {imm[11:5], rs2, rs1, 3'b011, imm[4:0], OPC_ST};
      OP_SW:   encode = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_ST};
      OP_BEQ:  encode = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OPC_BR};
      OP_BNE:  encode = {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11], OPC_BR};
      OP_BLT:  encode = {imm[12], imm[10:5], rs2, rs1, 3'b100, imm[4:1], imm[11], OPC_BR};
      OP_BGE:  encode = {imm[12], imm[10:5], rs2, rs1, 3'b101, imm[4:1], imm[11], OPC_BR};
      OP_JAL:  encode = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
      OP_JALR: encode = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
      OP_LUI:  encode = {imm[31:12], rd, OPC_LUI};
      OP_NOP:  encode = 32'h00000013;
      OP_BRK:  encode = 32'h00100073;
      OP_LI:   encode = {imm[11:0], 5'd0, 3'b000, rd, OPC_IMM};
      default: encode = 32'h0;
    endcase
  endfunction

  state_t      state, state_next;
  logic        slot_free;
  logic        load;
  logic [31:0] load_word;
  logic        load_last;
  logic        illegal_acc;
  logic        li_cap;
  logic        imm_small;
  logic [19:0] lui_upper;
  logic [4:0]  li_rd;
  logic [11:0] li_lo;

  assign slot_free = ~bus.out_valid | bus.out_ready;
  assign imm_small = (bus.req_imm[31:11] == {21{bus.req_imm[11]}});
  // Adding imm[11] compensates for ADDI sign-extending its 12-bit operand.
  assign lui_upper = bus.req_imm[31:12] + {19'd0, bus.req_imm[11]};

  always_comb begin
    state_next    = state;
    bus.req_ready = 1'b0;
    load          = 1'b0;
    load_word     = 32'h0;
    load_last     = 1'b0;
    illegal_acc   = 1'b0;
    li_cap        = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = slot_free;
        if (bus.req_valid && slot_free) begin
          if (bus.req_op > OP_LI) begin
            illegal_acc = 1'b1;
          end else if (bus.req_op == OP_LI && !imm_small) begin
            load       = 1'b1;
            load_word  = {lui_upper, bus.req_rd, OPC_LUI};
            li_cap     = 1'b1;
            state_next = LI2;
          end else begin
            load      = 1'b1;
            load_word = encode(bus.req_op, bus.req_rd, bus.req_rs1, bus.req_rs2, bus.req_imm);
            load_last = 1'b1;
          end
        end
      end
      LI2: begin
        if (slot_free) begin
          load       = 1'b1;
          load_word  = {li_lo, li_rd, 3'b000, li_rd, OPC_IMM};
          load_last  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.out_valid <= 1'b0;
      bus.out_instr <= 32'h0;
      bus.out_last  <= 1'b0;
      err           <= 1'b0;
      li_rd         <= 5'd0;
      li_lo         <= 12'd0;
    end else begin
      state <= state_next;
      err   <= illegal_acc;
      if (slot_free) begin
        bus.out_valid <= load;
        if (load) begin
          bus.out_instr <= load_word;
          bus.out_last  <= load_last;
        end
      end
      if (li_cap) begin
        li_rd <= bus.req_rd;
        li_lo <= bus.req_imm[11:0];
      end
    end
  end

  assign busy      = (state != IDLE) | bus.out_valid;
  assign state_dbg = state;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed cases plus randomized traffic checked
// against an arithmetic encoding model and an expected-word queue.
`timescale 1ns/1ps
module tb_instr_encoder;

  localparam int SHAMT_W = 6;

  logic       clk;
  logic       rst_n;
  logic       err;
  logic       busy;
  logic [1:0] state_dbg;

  instr_encoder_if bus();

  instr_encoder #(.SHAMT_W(SHAMT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .err       (err),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [32:0] exp_q[$];   // {last, word}
  bit          err_exp;
  bit          chk_en;
  bit          last_acc;
  int          n_cmp;
  int          n_bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint unsigned fld(input longint unsigned v, input int w, input int p);
    return (v & ((64'd1 << w) - 1)) << p;
  endfunction

  function automatic longint unsigned bits(input longint unsigned v, input int hi, input int lo);
    return (v >> lo) & ((64'd1 << (hi - lo + 1)) - 1);
  endfunction

  function automatic longint unsigned i_word(input longint unsigned iv, input int rs1,
                                             input int f3, input int rd, input int opc);
    return fld(iv, 12, 20) + fld(rs1, 5, 15) + fld(f3, 3, 12) + fld(rd, 5, 7) + opc;
  endfunction

  function automatic longint unsigned r_word(input int f7, input int rs2, input int rs1,
                                             input int f3, input int rd);
    return fld(f7, 7, 25) + fld(rs2, 5, 20) + fld(rs1, 5, 15) + fld(f3, 3, 12) + fld(rd, 5, 7) + 51;
  endfunction

  function automatic longint unsigned b_word(input longint unsigned u, input int rs2,
                                             input int rs1, input int f3);
    return fld(bits(u, 12, 12), 1, 31) + fld(bits(u, 10, 5), 6, 25) + fld(rs2, 5, 20) +
           fld(rs1, 5, 15) + fld(f3, 3, 12) + fld(bits(u, 4, 1), 4, 8) +
           fld(bits(u, 11, 11), 1, 7) + 99;
  endfunction

  function automatic longint unsigned s_word(input longint unsigned u, input int rs2,
                                             input int rs1, input int f3);
    return fld(bits(u, 11, 5), 7, 25) + fld(rs2, 5, 20) + fld(rs1, 5, 15) +
           fld(f3, 3, 12) + fld(bits(u, 4, 0), 5, 7) + 35;
  endfunction

  function automatic logic [31:0] model_enc(input int op, input int rd, input int rs1,
                                            input int rs2, input logic [31:0] imm);
    longint unsigned u;
    longint unsigned sh;
    longint unsigned w;
    u  = imm;
    sh = u % (64'd1 << SHAMT_W);
    case (op)
      0:  w = r_word(0, rs2, rs1, 0, rd);
      1:  w = r_word(32, rs2, rs1, 0, rd);
      2:  w = r_word(0, rs2, rs1, 1, rd);
      3:  w = r_word(0, rs2, rs1, 2, rd);
      4:  w = r_word(0, rs2, rs1, 7, rd);
      5:  w = i_word(u, rs1, 0, rd, 19);
      6:  w = i_word(u, rs1, 2, rd, 19);
      7:  w = i_word(sh, rs1, 1, rd, 19);
      8:  w = i_word(sh, rs1, 5, rd, 19);
      9:  w = i_word(sh + 16 * 64, rs1, 5, rd, 19);
      10: w = i_word(u, rs1, 3, rd, 3);
      11: w = i_word(u, rs1, 2, rd, 3);
      12: w = i_word(u, rs1, 1, rd, 3);
      13: w = i_word(u, rs1, 4, rd, 3);
      14: w = s_word(u, rs2, rs1, 3);
      15: w = s_word(u, rs2, rs1, 2);
      16: w = b_word(u, rs2, rs1, 0);
      17: w = b_word(u, rs2, rs1, 1);
      18: w = b_word(u, rs2, rs1, 4);
      19: w = b_word(u, rs2, rs1, 5);
      20: w = fld(bits(u, 20, 20), 1, 31) + fld(bits(u, 10, 1), 10, 21) +
              fld(bits(u, 11, 11), 1, 20) + fld(bits(u, 19, 12), 8, 12) + fld(rd, 5, 7) + 111;
      21: w = i_word(u, rs1, 0, rd, 103);
      22: w = fld(bits(u, 31, 12), 20, 12) + fld(rd, 5, 7) + 55;
      23: w = 19;
      24: w = 64'h00100073;
      default: w = 0;
    endcase
    return w[31:0];
  endfunction

  // Push every word a legal request must produce, in order.
  task automatic model_push(input int op, input int rd, input int rs1, input int rs2,
                            input logic [31:0] imm);
    longint s;
    longint unsigned upper;
    longint unsigned w;
    s = longint'($signed(imm));
    if (op != 25) begin
      exp_q.push_back({1'b1, model_enc(op, rd, rs1, rs2, imm)});
    end else if (s >= -2048 && s <= 2047) begin
      w = i_word(longint'(imm), 0, 0, rd, 19);
      exp_q.push_back({1'b1, w[31:0]});
    end else begin
      upper = longint'((s + 2048) >>> 12) & 64'hFFFFF;
      w = fld(upper, 20, 12) + fld(rd, 5, 7) + 55;
      exp_q.push_back({1'b0, w[31:0]});
      w = i_word(longint'(imm), rd, 0, rd, 19);
      exp_q.push_back({1'b1, w[31:0]});
    end
  endtask

  // The encoder takes a request only when no word is waiting behind the shown one.
  function automatic bit ready_exp(input bit ordy);
    return (exp_q.size() == 0) || (exp_q.size() == 1 && ordy);
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 64'(bus.out_valid), 64'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        chk("out_instr", 64'(bus.out_instr), 64'(exp_q[0][31:0]));
        chk("out_last", 64'(bus.out_last), 64'(exp_q[0][32]));
      end
      chk("err", 64'(err), 64'(err_exp));
      chk("busy", 64'(busy), 64'(exp_q.size() > 0));
      chk("req_ready", 64'(bus.req_ready), 64'(ready_exp(bus.out_ready)));
    end
  end

  // ---------------- driver ----------------
  task automatic step(input bit v, input logic [4:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input bit ordy);
    bit acc;
    @(negedge clk);
    #1;
    bus.req_valid = v;
    bus.req_op    = op;
    bus.req_rd    = rd;
    bus.req_rs1   = rs1;
    bus.req_rs2   = rs2;
    bus.req_imm   = imm;
    bus.out_ready = ordy;
    acc = v && ready_exp(ordy);
    if (exp_q.size() > 0 && ordy) void'(exp_q.pop_front());
    err_exp = acc && (op > 5'd25);
    if (acc && op <= 5'd25) model_push(int'(op), int'(rd), int'(rs1), int'(rs2), imm);
    last_acc = acc;
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, ordy);
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] imm_tab[6];
  logic [4:0]  c_op, c_rd, c_rs1, c_rs2;
  logic [31:0] c_imm;
  bit          c_v;

  initial begin
    n_cmp = 0; n_bad = 0; chk_en = 1'b0; err_exp = 1'b0; last_acc = 1'b0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = '0; bus.req_rd = '0; bus.req_rs1 = '0;
    bus.req_rs2 = '0; bus.req_imm = '0; bus.out_ready = 1'b0;
    imm_tab[0] = 32'd2047;      imm_tab[1] = 32'hFFFFF800;
    imm_tab[2] = 32'd2048;      imm_tab[3] = 32'hFFFFF7FF;
    imm_tab[4] = 32'h7FFFF800;  imm_tab[5] = 32'hFFFFFFFF;

    // model pinned to hand-encoded words
    chk("lit_add",  64'(model_enc(0, 3, 1, 2, 32'h0)), 64'h002081B3);
    chk("lit_addi", 64'(model_enc(5, 1, 0, 0, 32'hFFFFFFFF)), 64'hFFF00093);
    chk("lit_beq",  64'(model_enc(16, 0, 1, 2, 32'd8)), 64'h00208463);
    chk("lit_sd",   64'(model_enc(14, 0, 2, 3, 32'hFFFFFFF8)), 64'hFE313C23);
    chk("lit_srai", 64'(model_enc(9, 1, 1, 0, 32'd3)), 64'h4030D093);
    chk("lit_jal",  64'(model_enc(20, 1, 0, 0, 32'd2048)), 64'h001000EF);

    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_out_instr", 64'(bus.out_instr), 64'h0);
    chk("rst_out_last", 64'(bus.out_last), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;

    // ADD, latency 1
    step(1'b1, 5'd0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1);
    idle(1'b1);
    chk("add_word", 64'(bus.out_instr), 64'h002081B3);
    chk("add_last", 64'(bus.out_last), 64'h1);

    // LI long form: LUI then ADDI, no request taken in between
    step(1'b1, 5'd25, 5'd5, 5'd0, 5'd0, 32'h12345FFF, 1'b0);
    idle(1'b0);
    #1;
    chk("li_lui", 64'(bus.out_instr), 64'h123462B7);
    chk("li_lui_last", 64'(bus.out_last), 64'h0);
    chk("li_ready", 64'(bus.req_ready), 64'h0);
    idle(1'b1);
    idle(1'b1);
    chk("li_addi", 64'(bus.out_instr), 64'hFFF28293);
    chk("li_addi_last", 64'(bus.out_last), 64'h1);

    // SUB stalled by the consumer for 3 cycles, ADDI queued behind it
    step(1'b1, 5'd1, 5'd4, 5'd5, 5'd6, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'd5, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0);
      #1;
      chk("hold_word", 64'(bus.out_instr), 64'h40628233);
      chk("hold_ready", 64'(bus.req_ready), 64'h0);
    end
    step(1'b1, 5'd5, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1);
    idle(1'b1);
    chk("after_hold", 64'(bus.out_instr), 64'hFFF00093);

    // illegal op then NOP
    step(1'b1, 5'd31, 5'd7, 5'd7, 5'd7, 32'h5, 1'b1);
    idle(1'b1);
    chk("ill_err", 64'(err), 64'h1);
    chk("ill_valid", 64'(bus.out_valid), 64'h0);
    step(1'b1, 5'd23, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1);
    chk("ill_err_drop", 64'(err), 64'h0);
    idle(1'b1);
    chk("nop_word", 64'(bus.out_instr), 64'h00000013);

    // reset while the second LI word is pending
    step(1'b1, 5'd25, 5'd9, 5'd0, 5'd0, 32'h0ABCD123, 1'b0);
    idle(1'b0);
    #2;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    exp_q.delete();
    err_exp = 1'b0;
    #1;
    chk("rst_li2_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_li2_busy", 64'(busy), 64'h0);
    idle(1'b1);
    rst_n = 1'b1;
    step(1'b1, 5'd0, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1);
    idle(1'b1);
    chk("post_rst_add", 64'(bus.out_instr), 64'h002081B3);

    // randomized traffic; an unaccepted request is held unchanged
    c_v = 1'b0; c_op = '0; c_rd = '0; c_rs1 = '0; c_rs2 = '0; c_imm = '0;
    for (int n = 0; n < 600; n++) begin
      if (!(c_v && !last_acc)) begin
        c_v   = ($urandom_range(0, 9) < 7);
        c_op  = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 3) == 0) c_op = 5'd25;
        c_rd  = 5'($urandom_range(0, 31));
        c_rs1 = 5'($urandom_range(0, 31));
        c_rs2 = 5'($urandom_range(0, 31));
        case ($urandom_range(0, 2))
          0: c_imm = 32'(int'($urandom_range(0, 4095)) - 2048);
          1: c_imm = imm_tab[$urandom_range(0, 5)];
          default: c_imm = $urandom;
        endcase
      end
      step(c_v, c_op, c_rd, c_rs1, c_rs2, c_imm, ($urandom_range(0, 3) != 0));
    end

    for (int n = 0; n < 20; n++) begin
      if (exp_q.size() == 0) break;
      idle(1'b1);
    end
    idle(1'b1);
    chk("drain_empty", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
